// File: rtl/vga_scan_out_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_out_if
// Purpose  : Pixel-FIFO read port and VGA video outputs of the scan-out stage.
//            The master side is the scan-out engine. The slave side is the
//            FIFO plus the display sink.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_scan_out_if;
  logic        fifo_empty;
  logic        fifo_full;
  logic [23:0] fifo_dout;
  logic        fifo_rd;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [23:0] out_pixel;
  logic        underflow;

  modport master (
    input  fifo_empty, fifo_full, fifo_dout,
    output fifo_rd, hsync, vsync, blank, out_pixel, underflow
  );

  modport slave (
    output fifo_empty, fifo_full, fifo_dout,
    input  fifo_rd, hsync, vsync, blank, out_pixel, underflow
  );
endinterface
`default_nettype wire

// File: rtl/vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_out
// Purpose  : Pops 24-bit pixels from the display FIFO and generates VGA raster
//            timing (hsync, vsync, blank) with a registered RGB pixel. It
//            primes on a full FIFO at frame start and flags underflow.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_out #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           clk,
  input  logic           rst,
  vga_scan_out_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] CNT_ONE  = 10'd1;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    SCAN  = 1'b1
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [9:0]       h;
  logic [9:0]       v;

  logic pix_en;
  logic active;
  logic hs_n;
  logic vs_n;
  logic frame_start;
  logic want_pixel;
  logic rd;
  logic miss;

  // Values captured on the pix_en edge, presented one clock later
  logic ld;
  logic rd_q;
  logic hs_q;
  logic vs_q;
  logic blank_q;

  logic        hsync_r;
  logic        vsync_r;
  logic        blank_r;
  logic [23:0] pixel_r;
  logic        underflow_r;

  // Raster decode and read decision for the current pixel slot
  always_comb begin
    pix_en      = (div == DIV_LAST);
    active      = (h < H_ACT_C) && (v < V_ACT_C);
    hs_n        = !((h >= H_SS) && (h < H_SE));
    vs_n        = !((v >= V_SS) && (v < V_SE));
    frame_start = pix_en && (h == 10'd0) && (v == 10'd0) && bus.fifo_full;
    // The frame-start pixel is scanned in the same slot the FSM commits,
    // so a primed frame consumes every active pixel starting at (0,0).
    want_pixel  = ((state == SCAN) || frame_start) && pix_en && active;
    rd          = want_pixel && !bus.fifo_empty;
    miss        = want_pixel && bus.fifo_empty;
  end

  assign bus.fifo_rd = rd;

  // Pixel divider and horizontal/vertical position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (pix_en) begin
      div <= '0;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 10'd0 : v + CNT_ONE;
      end else begin
        h <= h + CNT_ONE;
      end
    end else begin
      div <= div + DIV_ONE;
    end
  end

  // Prime/scan FSM with the sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PRIME;
      underflow_r <= 1'b0;
    end else begin
      case (state)
        PRIME:   if (frame_start) state <= SCAN;
        SCAN:    state <= SCAN;
        default: state <= PRIME;
      endcase
      if (miss) underflow_r <= 1'b1;
    end
  end

  // Capture timing and read status of the pixel slot on its pix_en edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld      <= 1'b0;
      rd_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      ld   <= pix_en;
      rd_q <= rd;
      if (pix_en) begin
        hs_q    <= hs_n;
        vs_q    <= vs_n;
        blank_q <= !active;
      end
    end
  end

  // Output register, loaded the clock after pix_en once FIFO data is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      blank_r <= 1'b1;
      pixel_r <= 24'h000000;
    end else if (ld) begin
      hsync_r <= hs_q;
      vsync_r <= vs_q;
      blank_r <= blank_q;
      pixel_r <= rd_q ? bus.fifo_dout : 24'h000000;
    end
  end

  assign bus.hsync     = hsync_r;
  assign bus.vsync     = vsync_r;
  assign bus.blank     = blank_r;
  assign bus.out_pixel = pixel_r;
  assign bus.underflow = underflow_r;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_out
// Purpose  : Self-checking bench for vga_scan_out on a reduced 16x8 raster
//            (8x4 active, CLK_DIV=2, 256 clocks per frame) with a ramp FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_out;

  localparam int CD = 2;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_scan_out_if bus ();

  vga_scan_out #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ramp FIFO: each pop returns the next integer one clock later
  int src = 0;
  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      bus.fifo_dout <= 24'(src);
      src <= src + 1;
    end
  end

  // Clock index since reset release (cycle 0 is the first cycle after release)
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Behavioural model: position is derived from the clock index by division
  bit primed;
  int rdcount = 0;
  bit e_hs, e_vs, e_bl, e_uf;
  int e_pix;
  bit p_hs, p_vs, p_bl, p_load;
  int p_pix;
  int m_p, m_h, m_v;
  bit m_pe, m_act, m_scan, m_rd;
  // Observed statistics, cleared on reset
  int nrd, first_rd, last_rd, consec, hs_low, vs_low, first_vs;

  always @(negedge clk) begin
    if (rst) begin
      primed = 0;
      e_hs = 1; e_vs = 1; e_bl = 1; e_uf = 0; e_pix = 0;
      p_load = 0;
      nrd = 0; first_rd = -1; last_rd = -10; consec = 0;
      hs_low = 0; vs_low = 0; first_vs = -1;
    end else begin
      m_p    = cyc / CD;
      m_h    = m_p % HT;
      m_v    = (m_p / HT) % VT;
      m_pe   = (cyc % CD) == CD - 1;
      m_act  = (m_h < HA) && (m_v < VA);
      m_scan = primed || (m_pe && m_h == 0 && m_v == 0 && bus.fifo_full);
      m_rd   = m_scan && m_pe && m_act && !bus.fifo_empty;

      check("fifo_rd",   32'(bus.fifo_rd),   32'(m_rd));
      check("hsync",     32'(bus.hsync),     32'(e_hs));
      check("vsync",     32'(bus.vsync),     32'(e_vs));
      check("blank",     32'(bus.blank),     32'(e_bl));
      check("out_pixel", 32'(bus.out_pixel), 32'(e_pix));
      check("underflow", 32'(bus.underflow), 32'(e_uf));

      if (bus.fifo_rd) begin
        nrd++;
        if (first_rd < 0) first_rd = cyc;
        if (last_rd == cyc - 1) consec++;
        last_rd = cyc;
      end
      if (!bus.hsync) hs_low++;
      if (!bus.vsync) begin
        vs_low++;
        if (first_vs < 0) first_vs = cyc;
      end

      if (m_scan && m_pe && m_act && bus.fifo_empty) e_uf = 1;
      if (p_load) begin
        e_hs = p_hs; e_vs = p_vs; e_bl = p_bl; e_pix = p_pix;
        p_load = 0;
      end
      if (m_pe) begin
        p_hs   = !(m_h >= HA + HF && m_h < HA + HF + HS);
        p_vs   = !(m_v >= VA + VF && m_v < VA + VF + VS);
        p_bl   = !m_act;
        p_pix  = m_rd ? rdcount : 0;
        p_load = 1;
      end
      if (m_rd) rdcount++;
      primed = m_scan;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.fifo_full  = 1'b0;
    bus.fifo_empty = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_rd",   32'(bus.fifo_rd),   32'd0);
    check("rst_hsync",     32'(bus.hsync),     32'd1);
    check("rst_vsync",     32'(bus.vsync),     32'd1);
    check("rst_blank",     32'(bus.blank),     32'd1);
    check("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);

    // Never primed: timing runs, no reads
    rst = 1'b0;
    wait_cyc(256);
    check("prime_reads",    32'(nrd),      32'd0);
    check("prime_hs_low",   32'(hs_low),   32'd48);
    check("prime_vs_low",   32'(vs_low),   32'd64);
    check("prime_first_vs", 32'(first_vs), 32'd163);

    // Re-prime with a full FIFO
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.fifo_full = 1'b1;
    rst = 1'b0;
    wait_cyc(3);
    check("first_pixel", 32'(bus.out_pixel), 32'd0);
    check("first_blank", 32'(bus.blank),     32'd0);
    wait_cyc(5);
    check("second_pixel", 32'(bus.out_pixel), 32'd1);
    wait_cyc(32);
    check("line0_reads", 32'(nrd), 32'd8);
    wait_cyc(256);
    check("frame_reads",   32'(nrd),      32'd32);
    check("first_rd_cyc",  32'(first_rd), 32'd1);
    check("consec_reads",  32'(consec),   32'd0);
    check("scan_vs_low",   32'(vs_low),   32'd64);
    check("scan_first_vs", 32'(first_vs), 32'd163);

    // One empty slot at (3,1) of the second frame, full and empty together
    wait_cyc(295);
    bus.fifo_empty = 1'b1;
    wait_cyc(296);
    bus.fifo_empty = 1'b0;
    check("uf_set", 32'(bus.underflow), 32'd1);
    wait_cyc(297);
    check("miss_pixel", 32'(bus.out_pixel), 32'd0);
    check("miss_blank", 32'(bus.blank),     32'd0);
    wait_cyc(299);
    check("after_miss_pixel", 32'(bus.out_pixel), 32'd43);
    check("uf_sticky",        32'(bus.underflow), 32'd1);

    // Asynchronous reset between clock edges, mid-line
    wait_cyc(330);
    #2;
    rst = 1'b1;
    #1;
    check("arst_fifo_rd",   32'(bus.fifo_rd),   32'd0);
    check("arst_hsync",     32'(bus.hsync),     32'd1);
    check("arst_vsync",     32'(bus.vsync),     32'd1);
    check("arst_blank",     32'(bus.blank),     32'd1);
    check("arst_out_pixel", 32'(bus.out_pixel), 32'd0);
    check("arst_underflow", 32'(bus.underflow), 32'd0);
    @(posedge clk);
    #1;
    bus.fifo_full = 1'b0;
    rst = 1'b0;
    wait_cyc(100);
    bus.fifo_full = 1'b1;
    wait_cyc(400);
    check("reprime_first_rd", 32'(first_rd), 32'd257);
    check("reprime_reads",    32'(nrd),      32'd32);
    wait_cyc(520);
    check("final_underflow",  32'(bus.underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
